time_keeper: RTL and testbench

TIME_KEEPER -- requirements
Module: time_keeper

---
 rtl/time_keeper_if.sv | 31 +++
 rtl/time_keeper.sv | 111 +++++++++++
 tb/tb_time_keeper.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/time_keeper_if.sv
// Button/mode inputs and time display outputs of the watch, bundled for
// connection between the time_keeper core and its driver.
interface time_keeper_if;
    logic [1:0] KEY;
    logic [1:0] mode;
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
    logic       sec_tick;
    logic       sel;

    modport master (
        output KEY,
        output mode,
        input  hour,
        input  min,
        input  sec,
        input  sec_tick,
        input  sel
    );

    modport slave (
        input  KEY,
        input  mode,
        output hour,
        output min,
        output sec,
        output sec_tick,
        output sel
    );
endinterface

// File: rtl/time_keeper.sv
// 24-hour wall clock with a one-second prescaler and a two-button time-set
// mode (KEY[0] increments the selected field, KEY[1] toggles the selection).
module time_keeper #(
    parameter int CLK_HZ = 50000000
) (
    input  logic          CLOCK_50,
    input  logic          RESET,
    time_keeper_if.slave  bus
);
    localparam int            PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(CLK_HZ - 1);

    logic [1:0]    r_key_meta, r_key_sync, r_key_prev, r_armed;
    logic [1:0]    r_warm;
    logic [PW-1:0] r_presc;
    logic [7:0]    r_hour, r_min, r_sec;
    logic          r_tick, r_sel;

    logic          w_set_mode, w_hist_ok;
    logic [1:0]    w_press, w_accept, w_armed_next;
    logic [PW-1:0] w_presc_next;
    logic [7:0]    w_hour_next, w_min_next, w_sec_next;
    logic          w_tick_next, w_sel_next;

    assign w_set_mode = (bus.mode == 2'd1);
    // The key history is only trusted once real samples have replaced the
    // reset values in both sync and prev, so a button held through reset
    // never looks like a fresh press.
    assign w_hist_ok  = (r_warm == 2'd3);

    // A release counts only if its press was also seen inside set mode.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            assign w_press[gi]      = w_hist_ok & r_key_prev[gi] & ~r_key_sync[gi];
            assign w_accept[gi]     = w_set_mode & r_armed[gi] & ~r_key_prev[gi] & r_key_sync[gi];
            assign w_armed_next[gi] = w_set_mode & (w_press[gi] | (r_armed[gi] & ~w_accept[gi]));
        end
    endgenerate

    always_comb begin
        w_presc_next = r_presc;
        w_hour_next  = r_hour;
        w_min_next   = r_min;
        w_sec_next   = r_sec;
        w_tick_next  = 1'b0;
        w_sel_next   = r_sel;
        if (w_set_mode) begin
            w_presc_next = '0;
            w_sec_next   = 8'd0;
            if (w_accept[0]) begin
                if (r_sel)
                    w_hour_next = (r_hour >= 8'd23) ? 8'd0 : r_hour + 8'd1;
                else
                    w_min_next  = (r_min >= 8'd59) ? 8'd0 : r_min + 8'd1;
            end
            if (w_accept[1])
                w_sel_next = ~r_sel;
        end else if (r_presc == PS_LAST) begin
            w_presc_next = '0;
            w_tick_next  = 1'b1;
            if (r_sec >= 8'd59) begin
                w_sec_next = 8'd0;
                if (r_min >= 8'd59) begin
                    w_min_next  = 8'd0;
                    w_hour_next = (r_hour >= 8'd23) ? 8'd0 : r_hour + 8'd1;
                end else begin
                    w_min_next = r_min + 8'd1;
                end
            end else begin
                w_sec_next = r_sec + 8'd1;
            end
        end else begin
            w_presc_next = r_presc + PW'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_key_meta <= 2'b11;
            r_key_sync <= 2'b11;
            r_key_prev <= 2'b11;
            r_armed    <= 2'b00;
            r_warm     <= 2'd0;
            r_presc    <= '0;
            r_hour     <= 8'd0;
            r_min      <= 8'd0;
            r_sec      <= 8'd0;
            r_tick     <= 1'b0;
            r_sel      <= 1'b0;
        end else begin
            r_key_meta <= bus.KEY;
            r_key_sync <= r_key_meta;
            r_key_prev <= r_key_sync;
            r_armed    <= w_armed_next;
            if (r_warm != 2'd3)
                r_warm <= r_warm + 2'd1;
            r_presc    <= w_presc_next;
            r_hour     <= w_hour_next;
            r_min      <= w_min_next;
            r_sec      <= w_sec_next;
            r_tick     <= w_tick_next;
            r_sel      <= w_sel_next;
        end
    end

    assign bus.hour     = r_hour;
    assign bus.min      = r_min;
    assign bus.sec      = r_sec;
    assign bus.sec_tick = r_tick;
    assign bus.sel      = r_sel;
endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: a seconds-of-day model with scheduled key
// effects is compared every cycle, plus literal checkpoints from hand analysis.
module tb_time_keeper;
    localparam int CLK_HZ = 4;

    logic CLOCK_50 = 1'b0;
    logic RESET    = 1'b1;

    time_keeper_if bus ();

    time_keeper #(.CLK_HZ(CLK_HZ)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int dut_ticks = 0;
    bit valid = 0;

    // model state
    int m_hour = 0, m_min = 0, m_sec = 0, m_cnt = 0;
    bit m_tick = 0, m_sel = 0;
    bit [1:0] ev [int];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    always @(posedge CLOCK_50) begin
        int t;
        #1;
        edge_n++;
        if (RESET) begin
            m_hour = 0; m_min = 0; m_sec = 0; m_cnt = 0; m_tick = 0; m_sel = 0;
            valid = 1;
        end else if (bus.mode == 2'd1) begin
            m_cnt = 0; m_sec = 0; m_tick = 0;
            if (ev.exists(edge_n)) begin
                if (ev[edge_n][0]) begin
                    if (m_sel) m_hour = (m_hour + 1) % 24;
                    else       m_min  = (m_min + 1) % 60;
                end
                if (ev[edge_n][1]) m_sel = !m_sel;
            end
        end else begin
            m_cnt++;
            m_tick = 0;
            if (m_cnt == CLK_HZ) begin
                m_cnt = 0;
                m_tick = 1;
                t = (m_hour * 3600 + m_min * 60 + m_sec + 1) % 86400;
                m_hour = t / 3600;
                m_min  = (t / 60) % 60;
                m_sec  = t % 60;
            end
        end
        if (valid) begin
            chk("hour", int'(bus.hour), m_hour);
            chk("min", int'(bus.min), m_min);
            chk("sec", int'(bus.sec), m_sec);
            chk("sec_tick", int'(bus.sec_tick), int'(m_tick));
            chk("sel", int'(bus.sel), int'(m_sel));
            if (bus.sec_tick) dut_ticks++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic press(input logic [1:0] m);
        bus.KEY = bus.KEY & ~m;
        cyc(4);
    endtask

    // Raise the keys; an accepted release takes effect three edges later.
    task automatic release_k(input logic [1:0] m, input bit acc);
        int k;
        bus.KEY = bus.KEY | m;
        k = edge_n + 3;
        if (acc) begin
            if (!ev.exists(k)) ev[k] = 2'b00;
            ev[k] = ev[k] | m;
        end
        $display("release keys=%b accept=%0d effect_edge=%0d", m, acc, k);
        cyc(4);
    endtask

    task automatic tap(input logic [1:0] m, input int n);
        for (int i = 0; i < n; i++) begin
            press(m);
            release_k(m, 1'b1);
        end
    endtask

    task automatic lit_time(input string name, input int h, input int mi, input int s);
        chk({name, ".hour"}, int'(bus.hour), h);
        chk({name, ".min"}, int'(bus.min), mi);
        chk({name, ".sec"}, int'(bus.sec), s);
    endtask

    initial begin
        bus.KEY  = 2'b11;
        bus.mode = 2'd0;
        RESET    = 1'b1;
        cyc(2);
        RESET = 1'b0;
        lit_time("reset", 0, 0, 0);
        chk("reset.sel", int'(bus.sel), 0);
        chk("reset.tick", int'(bus.sec_tick), 0);

        // 61 seconds of free running
        dut_ticks = 0;
        cyc(4 * 61);
        chk("run61.ticks", dut_ticks, 61);
        lit_time("run61", 0, 1, 1);

        // set mode: sec clears, min/hour kept
        bus.mode = 2'd1;
        dut_ticks = 0;
        cyc(1);
        lit_time("setentry", 0, 1, 0);
        tap(2'b01, 58);
        chk("min59", int'(bus.min), 59);
        tap(2'b01, 1);
        lit_time("minwrap", 0, 0, 0);
        chk("set.noticks", dut_ticks, 0);

        // hour to 23, then simultaneous release
        tap(2'b10, 1);
        chk("sel1", int'(bus.sel), 1);
        tap(2'b01, 23);
        chk("hour23", int'(bus.hour), 23);
        press(2'b11);
        release_k(2'b11, 1'b1);
        chk("both.hour", int'(bus.hour), 0);
        chk("both.sel", int'(bus.sel), 0);
        chk("both.min", int'(bus.min), 0);

        // preload 23:59:00 then run to midnight
        tap(2'b10, 1);
        tap(2'b01, 23);
        tap(2'b10, 1);
        tap(2'b01, 59);
        lit_time("preload", 23, 59, 0);
        bus.mode = 2'd0;
        cyc(4 * 58);
        lit_time("t58", 23, 59, 58);
        chk("t58.tick", int'(bus.sec_tick), 1);
        cyc(4);
        lit_time("t59", 23, 59, 59);
        cyc(4);
        lit_time("midnight", 0, 0, 0);
        chk("midnight.tick", int'(bus.sec_tick), 1);

        // key held across the switch into set mode is not a release
        press(2'b01);
        cyc(6);
        bus.mode = 2'd1;
        cyc(2);
        release_k(2'b01, 1'b0);
        chk("heldswitch.min", int'(bus.min), 0);
        tap(2'b01, 1);
        chk("afterswitch.min", int'(bus.min), 1);

        // reach 12:34, sel=1, run to 12:34:55, reset on the next tick edge
        tap(2'b10, 1);
        tap(2'b01, 12);
        tap(2'b10, 1);
        tap(2'b01, 33);
        tap(2'b10, 1);
        lit_time("preset", 12, 34, 0);
        chk("preset.sel", int'(bus.sel), 1);
        bus.mode = 2'd0;
        bus.KEY  = 2'b01;
        cyc(4 * 55);
        lit_time("t55", 12, 34, 55);
        cyc(3);
        RESET    = 1'b1;
        bus.mode = 2'd1;
        cyc(1);
        RESET = 1'b0;
        lit_time("tickreset", 0, 0, 0);
        chk("tickreset.sel", int'(bus.sel), 0);
        chk("tickreset.tick", int'(bus.sec_tick), 0);
        cyc(5);
        release_k(2'b10, 1'b0);
        chk("heldreset.sel", int'(bus.sel), 0);
        tap(2'b10, 1);
        chk("repress.sel", int'(bus.sel), 1);

        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
